// File: rtl/k423_pipe_pkg.sv
// Shared types and limits for k423 inter-stage pipeline boundaries.
package k423_pipe_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_IDX_W      = 5;
    localparam int unsigned EXCP_CODE_W    = 5;
    localparam int unsigned LD_SIZE_W      = 3;
    localparam int unsigned PIPE_DEPTH_MAX = 16;

    // Example stage payload: ex -> wb boundary, packed by the stage top.
    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic                   rd_vld;
        logic [REG_IDX_W-1:0]   rd_idx;
        logic [XLEN-1:0]        rd;
        logic                   ld_vld;
        logic [LD_SIZE_W-1:0]   ld_size;
        logic                   ld_sext;
        logic                   excp_vld;
        logic [EXCP_CODE_W-1:0] excp_code;
        logic                   br_taken;
        logic [XLEN-1:0]        br_tgt;
        logic                   bju_upd_vld;
        logic [XLEN-1:0]        bju_upd_pc;
    } ex2wb_payload_t;

    localparam int unsigned EX2WB_W = $bits(ex2wb_payload_t);

endpackage

// File: rtl/k423_pipe_elastic.sv
// Elastic in-order pipeline buffer with valid/ready on both sides,
// flush (clear) and freeze (stall) controls, optional ready pass-through.
module k423_pipe_elastic
    import k423_pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned RDY_PASS = 0,
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pcu_clear_i,
    input  logic              pcu_stall_i,
    input  logic              up_vld_i,
    output logic              up_rdy_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_vld_o,
    input  logic              dn_rdy_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit          RP    = (RDY_PASS != 0);

    // Reject out-of-range depths at elaboration.
    if (DEPTH < 1 || DEPTH > PIPE_DEPTH_MAX) begin : g_depth_chk
        $error("k423_pipe_elastic: DEPTH out of range");
    end

    // Pointer increment that wraps DEPTH-1 -> 0 for any depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic empty;
    logic full;
    logic push;
    logic pop;

    // Handshake qualification; stall and clear both block acceptance.
    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == CNT_W'(DEPTH));
        up_rdy_o = !pcu_stall_i && !pcu_clear_i &&
                   (!full || (RP && dn_rdy_i && !empty));
        dn_vld_o = !empty && !pcu_stall_i;
        push     = up_vld_i && up_rdy_o;
        pop      = dn_vld_o && dn_rdy_i;
    end

    // Head payload, masked to zero when empty so stale entries never leak.
    always_comb begin
        dn_data_o = '0;
        if (!empty) begin
            dn_data_o = mem_q[rd_ptr_q];
        end
    end

    assign count_o = cnt_q;

    // Next-state for pointers and occupancy; clear beats push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (pcu_clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; only reset clears contents, a flush leaves them masked.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= up_data_i;
        end
    end

endmodule

// File: tb/tb_k423_pipe_elastic.sv
// Directed bench for k423_pipe_elastic across several depth/pass configs.
module tb_k423_pipe_elastic;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       stall;
    logic       vld;
    logic       rdy;
    logic [7:0] data;

    logic       u2_up_rdy, u2_dn_vld;
    logic [7:0] u2_dn_data;
    logic [1:0] u2_count;
    logic       u3_up_rdy, u3_dn_vld;
    logic [7:0] u3_dn_data;
    logic [1:0] u3_count;
    logic       p1_up_rdy, p1_dn_vld;
    logic [7:0] p1_dn_data;
    logic [0:0] p1_count;
    logic       n1_up_rdy, n1_dn_vld;
    logic [7:0] n1_dn_data;
    logic [0:0] n1_count;
    logic       u4_up_rdy, u4_dn_vld;
    logic [7:0] u4_dn_data;
    logic [2:0] u4_count;

    int n_tests = 0;
    int n_fail  = 0;

    k423_pipe_elastic #(.DATA_W(8), .DEPTH(2), .RDY_PASS(0)) u_d2 (
        .clk_i(clk), .rst_i(rst), .pcu_clear_i(clr), .pcu_stall_i(stall),
        .up_vld_i(vld), .up_rdy_o(u2_up_rdy), .up_data_i(data),
        .dn_vld_o(u2_dn_vld), .dn_rdy_i(rdy), .dn_data_o(u2_dn_data),
        .count_o(u2_count));

    k423_pipe_elastic #(.DATA_W(8), .DEPTH(3), .RDY_PASS(0)) u_d3 (
        .clk_i(clk), .rst_i(rst), .pcu_clear_i(clr), .pcu_stall_i(stall),
        .up_vld_i(vld), .up_rdy_o(u3_up_rdy), .up_data_i(data),
        .dn_vld_o(u3_dn_vld), .dn_rdy_i(rdy), .dn_data_o(u3_dn_data),
        .count_o(u3_count));

    k423_pipe_elastic #(.DATA_W(8), .DEPTH(1), .RDY_PASS(1)) u_p1 (
        .clk_i(clk), .rst_i(rst), .pcu_clear_i(clr), .pcu_stall_i(stall),
        .up_vld_i(vld), .up_rdy_o(p1_up_rdy), .up_data_i(data),
        .dn_vld_o(p1_dn_vld), .dn_rdy_i(rdy), .dn_data_o(p1_dn_data),
        .count_o(p1_count));

    k423_pipe_elastic #(.DATA_W(8), .DEPTH(1), .RDY_PASS(0)) u_n1 (
        .clk_i(clk), .rst_i(rst), .pcu_clear_i(clr), .pcu_stall_i(stall),
        .up_vld_i(vld), .up_rdy_o(n1_up_rdy), .up_data_i(data),
        .dn_vld_o(n1_dn_vld), .dn_rdy_i(rdy), .dn_data_o(n1_dn_data),
        .count_o(n1_count));

    k423_pipe_elastic #(.DATA_W(8), .DEPTH(4), .RDY_PASS(1)) u_d4 (
        .clk_i(clk), .rst_i(rst), .pcu_clear_i(clr), .pcu_stall_i(stall),
        .up_vld_i(vld), .up_rdy_o(u4_up_rdy), .up_data_i(data),
        .dn_vld_o(u4_dn_vld), .dn_rdy_i(rdy), .dn_data_o(u4_dn_data),
        .count_o(u4_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; stall = 1'b0;
        vld = 1'b0; rdy = 1'b0; data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    int tx, rx, cm, np1, nn1;
    logic s_push, s_pop;

    initial begin
        // Reset and fill, DEPTH=2
        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_vld",   u2_dn_vld,  1'b0);
        chk("rst_data",  u2_dn_data, 8'h00);
        chk("rst_count", u2_count,   2'd0);
        rst = 1'b0;
        vld = 1'b1; data = 8'hA1;
        #1;
        chk("fill_rdy0", u2_up_rdy, 1'b1);
        tick();
        chk("lat_vld",  u2_dn_vld,  1'b1);
        chk("lat_data", u2_dn_data, 8'hA1);
        data = 8'hA2;
        tick();
        vld = 1'b0;
        #1;
        chk("full_cnt",  u2_count,   2'd2);
        chk("full_rdy",  u2_up_rdy,  1'b0);
        chk("full_head", u2_dn_data, 8'hA1);
        rdy = 1'b1;
        #1;
        chk("drain_d0", u2_dn_data, 8'hA1);
        tick();
        chk("drain_d1", u2_dn_data, 8'hA2);
        tick();
        chk("drain_cnt",  u2_count,   2'd0);
        chk("drain_vld",  u2_dn_vld,  1'b0);
        chk("drain_data", u2_dn_data, 8'h00);
        rdy = 1'b0;

        // Streaming with random back-pressure, DEPTH=3
        do_reset();
        tx = 0; rx = 0; cm = 0;
        for (int cyc = 0; cyc < 2000 && rx < 100; cyc++) begin
            vld  = (tx < 100);
            data = 8'(tx);
            rdy  = ($urandom_range(0, 3) != 0);
            #1;
            chk("s_rdy", u3_up_rdy, (cm < 3));
            chk("s_vld", u3_dn_vld, (cm != 0));
            chk("s_cnt", u3_count,  32'(cm));
            s_push = vld && u3_up_rdy;
            s_pop  = u3_dn_vld && rdy;
            if (s_pop) begin
                chk("s_data", u3_dn_data, 32'(8'(rx)));
                rx++;
            end
            if (s_push) tx++;
            cm = cm + int'(s_push) - int'(s_pop);
            tick();
        end
        vld = 1'b0; rdy = 1'b0;
        #1;
        chk("s_done",  rx, 100);
        chk("s_empty", u3_count, 2'd0);

        // DEPTH=1 throughput with and without ready pass-through
        do_reset();
        vld = 1'b1; rdy = 1'b1;
        np1 = 0; nn1 = 0;
        for (int k = 0; k <= 10; k++) begin
            data = 8'(8'h10 + k);
            #1;
            if (k >= 1) begin
                if (p1_dn_vld && rdy) begin
                    np1++;
                    chk("p1_data", p1_dn_data, 32'(8'(8'h10 + k - 1)));
                end
                if (n1_dn_vld && rdy) nn1++;
            end
            tick();
        end
        vld = 1'b0; rdy = 1'b0;
        chk("p1_xfers", np1, 10);
        chk("n1_xfers", nn1, 5);

        // Clear concurrent with push while holding two entries
        do_reset();
        vld = 1'b1; data = 8'hB1;
        tick();
        data = 8'hB2;
        tick();
        chk("clr_pre_cnt", u2_count, 2'd2);
        data = 8'hC3; clr = 1'b1;
        #1;
        chk("clr_rdy", u2_up_rdy, 1'b0);
        tick();
        clr = 1'b0; vld = 1'b0;
        #1;
        chk("clr_cnt",  u2_count,   2'd0);
        chk("clr_vld",  u2_dn_vld,  1'b0);
        chk("clr_data", u2_dn_data, 8'h00);
        chk("clr_rdy1", u2_up_rdy,  1'b1);
        vld = 1'b1; data = 8'hD4;
        tick();
        vld = 1'b0;
        #1;
        chk("clr_after_data", u2_dn_data, 8'hD4);
        chk("clr_after_cnt",  u2_count,   2'd1);

        // Stall with head 0x55
        do_reset();
        vld = 1'b1; data = 8'h55;
        tick();
        data = 8'h66; stall = 1'b1; rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stl_vld",  u2_dn_vld,  1'b0);
            chk("stl_rdy",  u2_up_rdy,  1'b0);
            chk("stl_cnt",  u2_count,   2'd1);
            chk("stl_data", u2_dn_data, 8'h55);
            tick();
        end
        stall = 1'b0; vld = 1'b0;
        #1;
        chk("stl_rel_vld",  u2_dn_vld,  1'b1);
        chk("stl_rel_data", u2_dn_data, 8'h55);
        tick();
        rdy = 1'b0;
        #1;
        chk("stl_rel_cnt", u2_count, 2'd0);

        // Full pass-through on DEPTH=4: same-cycle push/pop, pointers wrap
        do_reset();
        vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data = 8'(8'h30 + k);
            tick();
        end
        rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data = 8'(8'h34 + k);
            #1;
            chk("rp_rdy",  u4_up_rdy,  1'b1);
            chk("rp_cnt",  u4_count,   3'd4);
            chk("rp_data", u4_dn_data, 32'(8'(8'h30 + k)));
            tick();
        end
        vld = 1'b0; rdy = 1'b0;

        // Reset asserted while full, DEPTH=4
        do_reset();
        vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data = 8'(8'hE0 + k);
            tick();
        end
        vld = 1'b0;
        #1;
        chk("rf_cnt", u4_count,  3'd4);
        chk("rf_rdy", u4_up_rdy, 1'b0);
        rst = 1'b1; vld = 1'b1; data = 8'hEE; rdy = 1'b1;
        tick();
        rst = 1'b0; vld = 1'b0; rdy = 1'b0;
        #1;
        chk("rf_post_cnt",  u4_count,   3'd0);
        chk("rf_post_vld",  u4_dn_vld,  1'b0);
        chk("rf_post_data", u4_dn_data, 8'h00);
        vld = 1'b1; data = 8'hF7;
        tick();
        vld = 1'b0;
        #1;
        chk("rf_new_data", u4_dn_data, 8'hF7);
        chk("rf_new_cnt",  u4_count,   3'd1);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        #1;
        chk("rf_end_cnt", u4_count,  3'd0);
        chk("rf_end_vld", u4_dn_vld, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
